// File: rtl/ifu_pkg.sv
// Shared fetch-unit types: FSM state encoding, bus response codes and the queue entry layout.
package ifu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RESP = 3'd2,
        KILL = 3'd3,
        HALT = 3'd4
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam int unsigned INST_STEP = 4;

    localparam int unsigned FETCH_AW = 32;
    localparam int unsigned FETCH_DW = 32;

    typedef struct packed {
        logic [FETCH_AW-1:0] pc;
        logic [FETCH_DW-1:0] inst;
        logic                fault;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Prefetch queue: DEPTH-entry FIFO, push visible at the head one cycle later, flush beats push.
// No internal backpressure: the caller's credit accounting guarantees a push never meets a full queue.
module ifu_fetch_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  entry_t                   push_dat_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output entry_t                   head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wptr_q;
    logic [PW-1:0]   rptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign do_push = push_i && (count_q != FULL);
    assign do_pop  = pop_i && (count_q != '0);

    // Pointers are PW bits wide, so they wrap mod DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wptr_q] <= push_dat_i;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch: single-outstanding sequential reads into a prefetch queue, redirect flush, fault capture.
// Head appears one cycle after the read-data handshake; requests stop when queue credit runs out.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc_i,
    output logic [ADDR_WIDTH-1:0]    araddr_o,
    output logic                     arvalid_o,
    input  logic                     arready_i,
    input  logic [DATA_WIDTH-1:0]    rdata_i,
    input  logic [1:0]               rresp_i,
    input  logic                     rvalid_i,
    output logic                     rready_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ADDR_WIDTH-1:0]    out_pc_o,
    output logic [DATA_WIDTH-1:0]    out_inst_o,
    output logic                     out_fault_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_M1 = CW'(DEPTH - 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
        logic                  fault;
    } entry_t;

    ifu_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic                    kill_pend_q, kill_pend_d;
    logic                    misalign_q, misalign_d;

    logic                    push;
    entry_t                  push_dat;
    logic                    pop;
    entry_t                  head;
    logic                    empty;
    logic [CW-1:0]           count;
    logic                    rsp_ok;
    logic                    credit_idle;
    logic                    room_after_push;

    assign pop    = !empty && out_ready_i;
    assign rsp_ok = (rresp_i == RESP_OKAY);

    // Only one request is ever in flight, so credit reduces to occupancy checks.
    assign credit_idle     = (count < FULL) || pop;
    assign room_after_push = pop ? (count < FULL) : (count < FULL_M1);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        araddr_d    = araddr_q;
        kill_pend_d = kill_pend_q;
        misalign_d  = misalign_q;
        push        = 1'b0;
        push_dat    = '0;

        case (state_q)
            IDLE: begin
                if (misalign_q) begin
                    push           = 1'b1;
                    push_dat.pc    = pc_q;
                    push_dat.fault = 1'b1;
                    misalign_d     = 1'b0;
                    state_d        = HALT;
                end else if (credit_idle) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (arready_i) begin
                    state_d     = kill_pend_q ? KILL : RESP;
                    kill_pend_d = 1'b0;
                end
            end
            RESP: begin
                if (rvalid_i) begin
                    push           = 1'b1;
                    push_dat.pc    = pc_q;
                    push_dat.inst  = rsp_ok ? rdata_i : '0;
                    push_dat.fault = !rsp_ok;
                    if (rsp_ok) begin
                        pc_d    = pc_q + ADDR_WIDTH'(INST_STEP);
                        state_d = room_after_push ? REQ : IDLE;
                    end else begin
                        state_d = HALT;
                    end
                end
            end
            KILL: begin
                if (rvalid_i) begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Redirect overrides everything; an accepted AR must still be drained via KILL.
        if (redirect_valid_i) begin
            push       = 1'b0;
            pc_d       = redirect_pc_i;
            misalign_d = is_misaligned(redirect_pc_i[1:0]);
            case (state_q)
                REQ: begin
                    state_d     = arready_i ? KILL : REQ;
                    kill_pend_d = !arready_i;
                end
                RESP, KILL: begin
                    state_d = rvalid_i ? IDLE : KILL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (state_d == REQ && state_q != REQ) begin
            araddr_d = pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            araddr_q    <= '0;
            kill_pend_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            araddr_q    <= araddr_d;
            kill_pend_q <= kill_pend_d;
            misalign_q  <= misalign_d;
        end
    end

    ifu_fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .flush_i    (redirect_valid_i),
        .head_o     (head),
        .empty_o    (empty),
        .count_o    (count)
    );

    assign arvalid_o   = (state_q == REQ);
    assign araddr_o    = araddr_q;
    assign rready_o    = (state_q == RESP) || (state_q == KILL);
    assign out_valid_o = !empty;
    // Stale storage behind an empty queue is masked so idle outputs read as zero.
    assign out_pc_o    = empty ? '0 : head.pc;
    assign out_inst_o  = empty ? '0 : head.inst;
    assign out_fault_o = empty ? 1'b0 : head.fault;
    assign count_o     = count;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: cycle table for sequential fetch, hand sequences for redirect/fault/reset.
module tb_ifu_fetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;
    logic [2:0]  count;

    logic [31:0] fault_addr = 32'hFFFF_FFF0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } obs_t;

    logic [31:0] ar_log [$];
    obs_t        out_log [$];

    int n_checks = 0;
    int n_fail   = 0;

    ifu_fetch_queue #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (32'h8000_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .araddr_o         (araddr),
        .arvalid_o        (arvalid),
        .arready_i        (arready),
        .rdata_i          (rdata),
        .rresp_i          (rresp),
        .rvalid_i         (rvalid),
        .rready_o         (rready),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_pc_o         (out_pc),
        .out_inst_o       (out_inst),
        .out_fault_o      (out_fault),
        .count_o          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Zero-wait memory: data one cycle after the AR handshake; also logs AR and delivered entries.
    initial begin : responder
        logic        hs;
        logic [31:0] a;
        rvalid = 1'b0;
        rdata  = '0;
        rresp  = '0;
        forever begin
            @(posedge clk);
            hs = rst && arvalid && arready;
            a  = araddr;
            if (hs) ar_log.push_back(a);
            if (rst && out_valid && out_ready) out_log.push_back({out_pc, out_inst, out_fault});
            #1;
            rvalid = hs;
            rdata  = hs ? mem_data(a) : 32'h0;
            rresp  = (hs && a == fault_addr) ? 2'b10 : 2'b00;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ar, input logic ordy);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        arready        = ar;
        out_ready      = ordy;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] target);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget, input string name);
        int k = 0;
        while (out_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(out_log.size() >= n), 32'd1);
    endtask

    task automatic check_out(input int idx, input string name, input logic [31:0] pc,
                             input logic [31:0] inst, input logic fault);
        if (idx >= out_log.size()) begin
            check({name, " present"}, 32'(out_log.size()), 32'(idx + 1));
        end else begin
            check({name, " pc"},    out_log[idx].pc,           pc);
            check({name, " inst"},  out_log[idx].inst,         inst);
            check({name, " fault"}, 32'(out_log[idx].fault),   32'(fault));
        end
    endtask

    task automatic check_ar(input int idx, input string name, input logic [31:0] addr);
        if (idx >= ar_log.size()) begin
            check({name, " present"}, 32'(ar_log.size()), 32'(idx + 1));
        end else begin
            check(name, ar_log[idx], addr);
        end
    endtask

    typedef struct {
        logic        out_ready;
        logic        ex_arvalid;
        logic [31:0] ex_araddr;
        logic        ex_rready;
        logic        ex_ovalid;
        logic [31:0] ex_opc;
        logic [31:0] ex_cnt;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        int ab;
        int ob;

        vecs[0] = '{1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0,          32'd0};
        vecs[1] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,          32'd0};
        vecs[2] = '{1'b1, 1'b1, 32'h8000_0004, 1'b0, 1'b1, 32'h8000_0000, 32'd1};
        vecs[3] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,          32'd0};
        vecs[4] = '{1'b1, 1'b1, 32'h8000_0008, 1'b0, 1'b1, 32'h8000_0004, 32'd1};
        vecs[5] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,          32'd0};
        vecs[6] = '{1'b1, 1'b1, 32'h8000_000C, 1'b0, 1'b1, 32'h8000_0008, 32'd1};

        // Reset state, then sequential fetch cycle by cycle.
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        arready        = 1'b1;
        out_ready      = 1'b1;
        @(negedge clk);
        check("rst arvalid",   32'(arvalid),   32'd0);
        check("rst rready",    32'(rready),    32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst count",     32'(count),     32'd0);
        check("rst out_pc",    out_pc,         32'd0);
        check("rst out_inst",  out_inst,       32'd0);
        check("rst out_fault", 32'(out_fault), 32'd0);
        do_reset(1'b1, 1'b1);
        @(negedge clk);
        check("c0 arvalid", 32'(arvalid), 32'd0);

        for (int i = 0; i < NV; i++) begin
            tick();
            out_ready = vecs[i].out_ready;
            @(negedge clk);
            check($sformatf("v%0d arvalid", i),   32'(arvalid),   32'(vecs[i].ex_arvalid));
            check($sformatf("v%0d rready", i),    32'(rready),    32'(vecs[i].ex_rready));
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ex_ovalid));
            check($sformatf("v%0d count", i),     32'(count),     vecs[i].ex_cnt);
            if (vecs[i].ex_arvalid)
                check($sformatf("v%0d araddr", i), araddr, vecs[i].ex_araddr);
            if (vecs[i].ex_ovalid) begin
                check($sformatf("v%0d out_pc", i),    out_pc,         vecs[i].ex_opc);
                check($sformatf("v%0d out_inst", i),  out_inst,       mem_data(vecs[i].ex_opc));
                check($sformatf("v%0d out_fault", i), 32'(out_fault), 32'd0);
            end
        end

        // Backpressure: queue fills to DEPTH, one pop frees exactly one request.
        do_reset(1'b1, 1'b0);
        ab = ar_log.size();
        ob = out_log.size();
        repeat (40) tick();
        @(negedge clk);
        check("bp requests", 32'(ar_log.size() - ab), 32'd4);
        check("bp count",    32'(count),              32'd4);
        check("bp arvalid",  32'(arvalid),            32'd0);
        check("bp head pc",  out_pc,                  32'h8000_0000);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        check("bp pop requests", 32'(ar_log.size() - ab), 32'd5);
        check_ar(ab + 4, "bp pop araddr", 32'h8000_0010);
        check("bp pop count",   32'(count),   32'd4);
        check("bp pop arvalid", 32'(arvalid), 32'd0);
        check_out(ob, "bp pop entry", 32'h8000_0000, mem_data(32'h8000_0000), 1'b0);

        // Redirect while REQ stalls on arready: address held, response discarded.
        do_reset(1'b0, 1'b1);
        ab = ar_log.size();
        ob = out_log.size();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1000;
        @(negedge clk);
        check("kill c1 arvalid", 32'(arvalid), 32'd1);
        check("kill c1 araddr",  araddr,       32'h8000_0000);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("kill c2 araddr",  araddr,       32'h8000_0000);
        check("kill c2 count",   32'(count),   32'd0);
        tick();
        @(negedge clk);
        check("kill c3 arvalid", 32'(arvalid), 32'd1);
        check("kill c3 araddr",  araddr,       32'h8000_0000);
        tick();
        arready = 1'b1;
        wait_out(ob + 1, 30, "kill resume");
        check_ar(ab,     "kill stale araddr", 32'h8000_0000);
        check_ar(ab + 1, "kill new araddr",   32'h8000_1000);
        check_out(ob, "kill first entry", 32'h8000_1000, mem_data(32'h8000_1000), 1'b0);

        // Bus fault halts fetch; misaligned redirect yields a fault entry; aligned redirect resumes.
        fault_addr = 32'h8000_0008;
        do_reset(1'b1, 1'b1);
        ab = ar_log.size();
        ob = out_log.size();
        wait_out(ob + 3, 40, "fault arrive");
        check_out(ob,     "fault e0", 32'h8000_0000, mem_data(32'h8000_0000), 1'b0);
        check_out(ob + 1, "fault e1", 32'h8000_0004, mem_data(32'h8000_0004), 1'b0);
        check_out(ob + 2, "fault e2", 32'h8000_0008, 32'h0,                    1'b1);
        repeat (10) tick();
        @(negedge clk);
        check("halt requests", 32'(ar_log.size() - ab), 32'd3);
        check("halt arvalid",  32'(arvalid),            32'd0);
        redirect(32'h8000_0102);
        wait_out(ob + 4, 20, "misalign arrive");
        check_out(ob + 3, "misalign entry", 32'h8000_0102, 32'h0, 1'b1);
        repeat (10) tick();
        @(negedge clk);
        check("misalign requests", 32'(ar_log.size() - ab), 32'd3);
        check("misalign arvalid",  32'(arvalid),            32'd0);
        redirect(32'h8000_0100);
        wait_out(ob + 6, 30, "resume arrive");
        check_ar(ab + 3, "resume araddr", 32'h8000_0100);
        check_out(ob + 4, "resume e0", 32'h8000_0100, mem_data(32'h8000_0100), 1'b0);
        check_out(ob + 5, "resume e1", 32'h8000_0104, mem_data(32'h8000_0104), 1'b0);
        fault_addr = 32'hFFFF_FFF0;

        // Asynchronous reset in the middle of a response.
        do_reset(1'b1, 1'b0);
        repeat (4) tick();
        @(negedge clk);
        check("mid pre rready", 32'(rready), 32'd1);
        check("mid pre count",  32'(count),  32'd1);
        #1 rst = 1'b0;
        #1;
        check("mid arvalid",   32'(arvalid),   32'd0);
        check("mid rready",    32'(rready),    32'd0);
        check("mid out_valid", 32'(out_valid), 32'd0);
        check("mid count",     32'(count),     32'd0);
        check("mid out_pc",    out_pc,         32'd0);
        check("mid out_inst",  out_inst,       32'd0);
        check("mid out_fault", 32'(out_fault), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        ab = ar_log.size();
        begin
            int k = 0;
            while (ar_log.size() <= ab && k < 10) begin
                @(negedge clk);
                k++;
            end
        end
        check_ar(ab, "post-reset araddr", 32'h8000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- Parametrised next-generation instruction fetch unit; sits between the PC redirect sources (EXU branch/jump, CSR trap/mret) and the IDU.
- Issues single-outstanding AXI4-Lite-style read requests for sequential PCs and buffers returned instructions in a DEPTH-entry prefetch queue.
- Supports flush-on-redirect with stale-response discard, and fault capture: bus error or misaligned target.
- Delivers {pc, inst, fault} to the IDU over a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 32, fetch address width.
- DATA_WIDTH, 32, instruction width.
- DEPTH, 4, prefetch queue entries; power of two, >= 2.
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- redirect_valid_i  in  1  redirect request; single pre-arbitrated source.
- redirect_pc_i  in  ADDR_WIDTH  redirect target.
- araddr_o  out  ADDR_WIDTH  read address.
- arvalid_o  out  1  read address valid.
- arready_i  in  1  read address accepted.
- rdata_i  in  DATA_WIDTH  read data.
- rresp_i  in  2  read response; 2'b00 = OKAY, else fault.
- rvalid_i  in  1  read data valid.
- rready_o  out  1  read data ready.
- out_valid_o  out  1  queue head valid to IDU.
- out_ready_i  in  1  IDU accepts head.
- out_pc_o  out  ADDR_WIDTH  head PC.
- out_inst_o  out  DATA_WIDTH  head instruction; 0 when fault.
- out_fault_o  out  1  head carries fetch fault.
- count_o  out  $clog2(DEPTH)+1  queue occupancy.

Behaviour:
- Reset (rst=0, async):
  - fetch pc = RESET_PC; state = IDLE; queue empty.
  - arvalid_o = 0, rready_o = 0, out_valid_o = 0, count_o = 0.
  - out_pc_o, out_inst_o, out_fault_o = 0.
- States: IDLE, REQ, RESP, KILL, HALT.
- arvalid_o = (state == REQ). araddr_o = fetch pc, held stable while in REQ.
- rready_o = (state == RESP or KILL).
- Credit rule: a request is issued only when count plus in-flight requests is less than DEPTH. At most one request is ever in flight, so a push never hits a full queue.
- IDLE -> REQ when credit is available and there is no redirect.
- REQ -> RESP on arvalid & arready_i.
- RESP, on rvalid_i:
  - Push {fetch pc, rdata or 0, rresp != OKAY}.
  - rresp == OKAY: pc <= pc + 4 (wraps mod 2^ADDR_WIDTH); go to REQ if credit remains after the push, else IDLE.
  - Fault: pc unchanged; go to HALT. No further requests until redirect.
- Timing: first arvalid in the cycle after rst deasserts. With zero-wait memory, an instruction reaches out_valid_o one cycle after the rvalid handshake; steady-state throughput is 1 instruction per 2 cycles.
- Redirect always wins over every other event in the same cycle:
  - Queue is flushed (count <= 0); any push that cycle is suppressed.
  - A pop in the same cycle counts as delivered.
  - pc <= redirect_pc_i.
- Redirect target with pc[1:0] != 0: no bus request is made. Push a fault entry {target, 0, 1} on the next cycle, then go to HALT.
- Redirect per state:
  - IDLE: stay IDLE; issue from the new pc next cycle.
  - REQ: arvalid must stay high (protocol). Set kill_pending; on the handshake go to KILL. If arready_i is high in the same cycle, go to KILL directly.
  - RESP: if rvalid_i is high the same cycle, drop the data and go to IDLE; else go to KILL.
  - KILL: pc updated; remain in KILL.
  - HALT: go to IDLE.
- KILL: on rvalid_i, discard the data (no push, pc unchanged) and go to IDLE.
- Queue push and pop in the same cycle: count is unchanged; ordering is FIFO. Read and write pointers wrap mod DEPTH.
- out_* reflect the queue head registers; stable while out_valid_o & !out_ready_i.

Decomposition:
- Package ifu_pkg:
  - state enum (IDLE/REQ/RESP/KILL/HALT).
  - RESP_OKAY = 2'b00.
  - INST_STEP = 4.
  - fetch-entry struct {pc, inst, fault}.
- One sub-module: ifu_fetch_fifo.
  - Synchronous DEPTH-entry FIFO with push, pop and flush; flush has priority over push.
  - Async active-low reset; outputs head entry, empty and count.

Test Plan:
- Reset release, arready=1, rvalid one cycle after handshake, out_ready=1 -> araddr sequence 0x80000000, 0x80000004, 0x80000008; out_pc matches in order; out_fault=0.
- out_ready=0, DEPTH=4 -> exactly 4 requests issued; count_o=4; arvalid stays 0. Then one pop -> exactly one new request.
- Redirect to 0x80001000 while in REQ with arready delayed 3 cycles -> araddr stays stable until the handshake; returned data discarded; next araddr=0x80001000; count_o=0 after the redirect.
- rresp=2'b10 at pc 0x80000008 -> entry out_fault=1, out_inst=0; no further arvalid. Redirect to 0x80000100 -> fetching resumes there.
- Redirect to 0x80000102 -> no arvalid; fault entry with out_pc=0x80000102; HALT.
- Assert rst low mid-RESP -> all outputs are at reset values immediately, without waiting for a clock edge. After release, first araddr=RESET_PC.
